// File: rtl/shift_pkg.sv
// Shared types and elaboration helpers for the shift_pipe barrel shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    // Width-independent part of a stage record; data and cnt are added in shift_pipe.
    typedef struct packed {
        shift_op_e op;
        logic      sign;
        logic      valid;
    } stage_ctl_t;

    function automatic int unsigned level_stage(input int unsigned level,
                                                input int unsigned levels,
                                                input int unsigned stages);
        return (level * stages) / levels;
    endfunction

    function automatic logic stage_first(input int unsigned level,
                                         input int unsigned levels,
                                         input int unsigned stages);
        if (level == 0)
            return 1'b1;
        return level_stage(level - 1, levels, stages) != level_stage(level, levels, stages);
    endfunction

    function automatic logic stage_last(input int unsigned level,
                                        input int unsigned levels,
                                        input int unsigned stages);
        if (level == levels - 1)
            return 1'b1;
        return level_stage(level + 1, levels, stages) != level_stage(level, levels, stages);
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-shifter mux level: shifts/rotates by DIST when en is set.
module shift_level
    import shift_pkg::*;
#(
    parameter int unsigned N    = 16,
    parameter int unsigned DIST = 1
) (
    input  logic [N-1:0] in_data,
    input  shift_op_e    op,
    input  logic         sign,
    input  logic         en,
    output logic [N-1:0] out_data
);

    always_comb begin
        out_data = in_data;
        if (en) begin
            case (op)
                SH_SLL:  out_data = {in_data[N-1-DIST:0], {DIST{1'b0}}};
                SH_SRL:  out_data = {{DIST{1'b0}}, in_data[N-1:DIST]};
                SH_SRA:  out_data = {{DIST{sign}}, in_data[N-1:DIST]};
                SH_ROR:  out_data = {in_data[DIST-1:0], in_data[N-1:DIST]};
                default: out_data = in_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined N-bit barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both ends.
// Define SHIFT_PIPE_ROL_EN to add in_rol: op ROR with in_rol=1 rotates left instead.
module shift_pipe
    import shift_pkg::*;
#(
    parameter  int unsigned N          = 16,
    localparam int unsigned C          = $clog2(N),
    parameter  int unsigned REG_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [C-1:0] in_cnt,
    input  logic [1:0]   in_op,
`ifdef SHIFT_PIPE_ROL_EN
    input  logic         in_rol,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    typedef struct packed {
        logic [N-1:0] data;
        logic [C-1:0] cnt;
        stage_ctl_t   ctl;
    } stage_t;

    stage_t                         stg_q   [REG_STAGES];
    stage_t                         stg_in  [REG_STAGES];
    stage_t                         stg_nxt [REG_STAGES];
    logic [REG_STAGES-1:0][N-1:0]   stg_res;
    logic [C-1:0][N-1:0]            lvl_out;
    logic [REG_STAGES-1:0]          adv;
    logic [C-1:0]                   cnt_eff;
    logic                           all_full;

`ifdef SHIFT_PIPE_ROL_EN
    // Rotate-left by k equals rotate-right by (N-k) mod N; N is a power of two.
    always_comb begin
        cnt_eff = in_cnt;
        if (shift_op_e'(in_op) == SH_ROR && in_rol)
            cnt_eff = '0 - in_cnt;
    end
`else
    assign cnt_eff = in_cnt;
`endif

    always_comb begin
        stg_in[0].data      = in_data;
        stg_in[0].cnt       = cnt_eff;
        stg_in[0].ctl.op    = shift_op_e'(in_op);
        stg_in[0].ctl.sign  = in_data[N-1];
        stg_in[0].ctl.valid = in_valid;
        for (int unsigned s = 1; s < REG_STAGES; s++)
            stg_in[s] = stg_q[s-1];
    end

    // "Stage s advances if empty or s+1 advances" unrolled to: downstream ready,
    // or some stage from s to the tail is empty. Avoids a self-referencing vector.
    always_comb begin
        all_full = 1'b1;
        adv      = '0;
        for (int unsigned i = 0; i < REG_STAGES; i++) begin
            all_full = all_full & stg_q[REG_STAGES-1-i].ctl.valid;
            adv[REG_STAGES-1-i] = out_ready || !all_full;
        end
    end

    for (genvar k = 0; k < C; k++) begin : g_lvl
        localparam int unsigned S = level_stage(k, C, REG_STAGES);
        logic [N-1:0] src;

        if (stage_first(k, C, REG_STAGES)) begin : g_head
            assign src = stg_in[S].data;
        end else begin : g_chain
            assign src = lvl_out[k-1];
        end

        shift_level #(
            .N    (N),
            .DIST (1 << k)
        ) u_level (
            .in_data  (src),
            .op       (stg_in[S].ctl.op),
            .sign     (stg_in[S].ctl.sign),
            .en       (stg_in[S].cnt[k]),
            .out_data (lvl_out[k])
        );

        if (stage_last(k, C, REG_STAGES)) begin : g_tail
            assign stg_res[S] = lvl_out[k];
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < REG_STAGES; s++) begin
            stg_nxt[s]      = stg_in[s];
            stg_nxt[s].data = stg_res[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < REG_STAGES; s++)
                stg_q[s] <= '0;
        end else begin
            for (int unsigned s = 0; s < REG_STAGES; s++)
                if (adv[s])
                    stg_q[s] <= stg_nxt[s];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = stg_q[REG_STAGES-1].ctl.valid;
    assign out_data  = stg_q[REG_STAGES-1].data;

    // The final stage's shift controls have no consumer.
    logic unused_tail;
    assign unused_tail = ^{stg_q[REG_STAGES-1].cnt, stg_q[REG_STAGES-1].ctl.op,
                           stg_q[REG_STAGES-1].ctl.sign};

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (N=16, REG_STAGES=2); ROL cases need SHIFT_PIPE_ROL_EN.
module tb_shift_pipe;

    localparam int unsigned N = 16;
    localparam int unsigned R = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
`ifdef SHIFT_PIPE_ROL_EN
    logic        in_rol;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit rnd_mode = 1'b0;

    logic [15:0] exp_q[$];
    int          acc_q[$];
    bit          strict_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_pipe #(
        .N          (N),
        .REG_STAGES (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
`ifdef SHIFT_PIPE_ROL_EN
        .in_rol    (in_rol),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] c,
                                          input logic [1:0] op);
        logic [31:0] dd;
        dd = {d, d};
        case (op)
            2'd0:    return d << c;
            2'd1:    return d >> c;
            2'd2:    return 16'($signed(d) >>> c);
            default: return 16'(dd >> c);
        endcase
    endfunction

    // Monitor: every handshaken output is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", {31'b0, out_valid}, 32'd0);
            end else begin
                logic [15:0] e;
                int          a;
                bit          st;
                e  = exp_q.pop_front();
                a  = acc_q.pop_front();
                st = strict_q.pop_front();
                chk("result", {16'b0, out_data}, {16'b0, e});
                if (st)
                    chk("latency", 32'(cyc - a), R);
            end
        end
    end

    // Called at posedge+1 (or at a negedge); returns at posedge+1 after acceptance.
    task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                        input logic [15:0] e, input bit strict);
        in_data  = d;
        in_cnt   = c;
        in_op    = op;
        in_valid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                acc_q.push_back(cyc);
                strict_q.push_back(strict);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 300 && exp_q.size() != 0; w++)
            @(negedge clk);
        chk("drain_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_mode)
            out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_op     = '0;
        out_ready = 1'b1;
`ifdef SHIFT_PIPE_ROL_EN
        in_rol    = 1'b0;
`endif
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", {16'b0, out_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Op sweep, back to back, latency checked.
        send(16'h8001, 4'd4,  2'd1, 16'h0800, 1'b1);
        send(16'h8001, 4'd4,  2'd2, 16'hF800, 1'b1);
        send(16'h8001, 4'd4,  2'd3, 16'h1800, 1'b1);
        send(16'h8001, 4'd4,  2'd0, 16'h0010, 1'b1);
        // Boundaries and extra directed vectors.
        send(16'h8001, 4'd15, 2'd0, 16'h8000, 1'b1);
        send(16'h8000, 4'd15, 2'd2, 16'hFFFF, 1'b1);
        send(16'h1234, 4'd0,  2'd3, 16'h1234, 1'b1);
        send(16'hFFFF, 4'd15, 2'd1, 16'h0001, 1'b1);
        send(16'h7FFF, 4'd3,  2'd2, 16'h0FFF, 1'b1);
        send(16'h0001, 4'd1,  2'd3, 16'h8000, 1'b1);
        send(16'h1234, 4'd0,  2'd0, 16'h1234, 1'b1);
        send(16'h8000, 4'd1,  2'd2, 16'hC000, 1'b1);
        send(16'h1234, 4'd8,  2'd3, 16'h3412, 1'b1);
        send(16'h1234, 4'd7,  2'd1, 16'h0024, 1'b1);
        drain();

        // Backpressure: two accepted, third stalls, drain accepts it alongside the first.
        out_ready = 1'b0;
        send(16'h00F0, 4'd4, 2'd1, 16'h000F, 1'b0);
        send(16'h0001, 4'd1, 2'd0, 16'h0002, 1'b0);
        in_data  = 16'h1234;
        in_cnt   = 4'd8;
        in_op    = 2'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_out_data_hold", {16'b0, out_data}, 32'h000F);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        #1 chk("bp_in_ready_on_drain", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        exp_q.push_back(16'h3412);
        acc_q.push_back(cyc);
        strict_q.push_back(1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset with two transactions in flight: nothing from them may appear.
        send(16'h8001, 4'd4, 2'd1, 16'h0800, 1'b0);
        send(16'h8001, 4'd4, 2'd0, 16'h0010, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_out_data", {16'b0, out_data}, 32'd0);
        exp_q.delete();
        acc_q.delete();
        strict_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rst_release_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (6) @(negedge clk);
        chk("rst_no_stale", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

`ifdef SHIFT_PIPE_ROL_EN
        in_rol = 1'b1;
        send(16'h8001, 4'd4, 2'd3, 16'h0018, 1'b1);
        send(16'h8001, 4'd0, 2'd3, 16'h8001, 1'b1);
        in_rol = 1'b0;
        drain();
`endif

        // Random stream with bubbles and random downstream stalls.
        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            logic [3:0]  c;
            logic [1:0]  op;
            d  = 16'($urandom);
            c  = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(d, c, op, model(d, c, op), 1'b0);
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised N-bit pipelined barrel shifter with four operations: SLL, SRL, SRA and ROR.
- Built from log2(N) mux levels (1, 2, 4, ... 2^(C-1)), split across REG_STAGES register stages.
- valid/ready handshake with full backpressure on both ends.
- Sits between the execute-stage operand mux and the writeback select. Also used standalone by multi-cycle shift/rotate instructions.

Parameters:
- N, 16, data width; power of two, >= 4.
- C, $clog2(N), count width; derived, must not be overridden.
- REG_STAGES, 2, number of pipeline register stages; legal range 1..C.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_data  in  N  operand.
- in_cnt  in  C  shift distance, 0..N-1.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  N  result.

Behaviour:
- Reset: one clock and one reset only. Reset is asynchronous and active-low: rst_n low clears every stage valid and zeroes every stage data, cnt and op register.
  - out_valid=0, out_data=0.
  - in_ready=1 as soon as rst_n is high.
- Reset mid-operation: all in-flight transactions are discarded and no output is produced for them.
- Level k (distance 2^k) is applied when cnt[k]=1. Fill bits per op:
  - SLL: zero fill from bit 0.
  - SRL: zero fill from bit N-1.
  - SRA: fill with the original operand bit N-1. This sign bit is carried through the pipeline with the data.
  - ROR: bits shifted out at bit 0 re-enter at bit N-1.
- Level k belongs to register stage floor(k*REG_STAGES/C). Each stage performs its levels combinationally, then registers data, cnt, op, sign and valid.
- Latency:
  - Exactly REG_STAGES cycles from acceptance to out_valid with no stall.
  - Throughput is 1 per cycle.
- Handshake:
  - Stage s advances when it is empty or stage s+1 advances. The last stage advances when out_ready=1 or it is empty.
  - in_ready = stage0 advances.
  - in_ready is combinational from the valids and out_ready only. It does not depend on in_valid.
  - While out_valid=1 and out_ready=0, out_data and all stage contents hold unchanged.
  - A full pipeline holds REG_STAGES transactions. A bubble (in_valid=0) propagates as an empty stage.
  - Simultaneous accept at the input and drain at the output in the same cycle is allowed, with no lost or duplicated transaction.
- cnt=0 returns in_data unchanged for all ops.
- Results are in acceptance order. No reordering.
- Unknown state: none. All 4 op codes are defined.

Optional Feature:
- Macro: SHIFT_PIPE_ROL_EN.
- When defined:
  - Adds input in_rol (1 bit).
  - With in_op=11 and in_rol=1, the block performs rotate-left by in_cnt, implemented as ROR by (N - in_cnt) mod N.
  - The conversion is done before stage 0 and adds no latency.
- When undefined:
  - No in_rol port.
  - op 11 is always ROR.

Decomposition:
- Package shift_pkg holds:
  - typedef enum logic [1:0] shift_op_e {SH_SLL, SH_SRL, SH_SRA, SH_ROR}.
  - Stage record struct: data, cnt, op, sign, valid.
  - Helper function computing the stage index of a level.
- One sub-module, shift_level: a single combinational mux level. Parameters N and DIST; inputs data, op, sign, en; output data.
- shift_pipe instantiates C shift_level instances plus REG_STAGES register slices.

Test Plan (N=16, REG_STAGES=2 unless stated):
- Reset: rst_n=0 asserted mid-stream with 2 transactions in flight -> out_valid=0 and out_data=0000 immediately. After release, in_ready=1 and no stale result appears.
- Op sweep with in_data=8001 and cnt=4:
  - SRL -> 0800.
  - SRA -> F800.
  - ROR -> 1800.
  - SLL -> 0010.
  - Each result appears exactly 2 cycles after acceptance.
- Boundaries:
  - SLL 8001 by 15 -> 8000.
  - SRA 8000 by 15 -> FFFF.
  - ROR 1234 by 0 -> 1234.
  - SRL FFFF by 15 -> 0001.
- Backpressure: out_ready=0 while 3 requests are offered -> 2 accepted, in_ready=0 on the third, out_data stable. Then out_ready=1 -> results drain in order one per cycle and the third request is accepted in the same cycle the first drains.
- Streaming with random bubbles and random out_ready over 10k ops, REG_STAGES in {1,2,4} -> every result matches a reference model, order is preserved, and no drops or duplicates occur.
- SHIFT_PIPE_ROL_EN defined: op 11 with rol=1 on 8001 by 4 -> 0018. Same operand with rol=1 and cnt=0 -> 8001.
